// File: rtl/car_request_conditioner.sv
// Sensor front end for the traffic light controller: synchronise, debounce and
// latch each street's vehicle request, forwarding it once the cross street's green has been held.
module car_request_conditioner #(
  parameter int DEBOUNCE  = 4,
  parameter int MIN_GREEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensA,
  input  logic       sensB,
  input  logic [2:0] lightsA,
  input  logic [2:0] lightsB,
  output logic       carA,
  output logic       carB,
  output logic       reqA,
  output logic       reqB
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int GW = $clog2(MIN_GREEN) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [GW-1:0] G_MAX    = GW'(MIN_GREEN);
  localparam logic [GW-1:0] G_ZERO   = GW'(1'b0);

  // Index 0 is A Street, index 1 is B Street.
  logic [1:0]    sens_s;
  logic [1:0]    green_s;
  logic [1:0]    hold_done_s;
  logic          lamp_unused_s;

  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    req_q, req_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [GW-1:0] g_q   [2];
  logic [GW-1:0] g_d   [2];

  assign sens_s        = {sensB, sensA};
  assign green_s       = {lightsB[0], lightsA[0]};
  assign lamp_unused_s = ^{lightsA[2:1], lightsB[2:1]};

  // Next-state logic for both streets: debounce counter, request latch, green hold timer.
  always_comb begin
    s1_d        = sens_s;
    s2_d        = s1_q;
    deb_d       = deb_q;
    req_d       = req_q;
    hold_done_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      g_d[i]   = g_q[i];

      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end

      // Serving the street clears its request even if a set arrives on the same edge.
      req_d[i] = (req_q[i] | deb_q[i]) & ~green_s[i];

      if (!green_s[i]) begin
        g_d[i] = G_ZERO;
      end else if (g_q[i] == G_MAX) begin
        g_d[i] = g_q[i];
      end else begin
        g_d[i] = g_q[i] + GW'(1'b1);
      end

      hold_done_s[i] = ~green_s[i] | (g_q[i] == G_MAX);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 2'b00;
      s2_q  <= 2'b00;
      deb_q <= 2'b00;
      req_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= CNT_ZERO;
        g_q[i]   <= G_ZERO;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      req_q <= req_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
        g_q[i]   <= g_d[i];
      end
    end
  end

  // Reset masks the outputs so they read 0 during the reset cycle itself.
  assign reqA = req_q[0] & ~reset;
  assign reqB = req_q[1] & ~reset;
  assign carA = req_q[0] & hold_done_s[1] & ~reset;
  assign carB = req_q[1] & hold_done_s[0] & ~reset;

endmodule

// File: tb/tb_car_request_conditioner.sv
// Self-checking bench for car_request_conditioner: directed scenarios plus a
// randomized run against a sample-window reference model.
module tb_car_request_conditioner;

  localparam int DEBOUNCE  = 4;
  localparam int MIN_GREEN = 8;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk;
  logic       reset;
  logic       sensA, sensB;
  logic [2:0] lightsA, lightsB;
  logic       carA, carB, reqA, reqB;

  int checks = 0;
  int passed = 0;

  // Reference model: raw sensor samples per edge, accepted level, request, green run length.
  bit [63:0] m_hist [2];
  bit        m_deb  [2];
  bit        m_req  [2];
  int        m_grun [2];

  car_request_conditioner #(.DEBOUNCE(DEBOUNCE), .MIN_GREEN(MIN_GREEN)) dut (
    .clk(clk), .reset(reset), .sensA(sensA), .sensB(sensB),
    .lightsA(lightsA), .lightsB(lightsB),
    .carA(carA), .carB(carB), .reqA(reqA), .reqB(reqB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_out();
    bit hold_a, hold_b, r;
    hold_a = !lightsA[0] || (m_grun[0] >= MIN_GREEN);
    hold_b = !lightsB[0] || (m_grun[1] >= MIN_GREEN);
    r = reset;
    return {m_req[0] & hold_b & !r, m_req[1] & hold_a & !r, m_req[0] & !r, m_req[1] & !r};
  endfunction

  // A level is accepted once the synchronised sensor (sampled two edges late)
  // has differed from it on DEBOUNCE consecutive edges.
  task automatic model_edge();
    bit sens [2];
    bit grn  [2];
    bit flip;
    sens[0] = sensA;      sens[1] = sensB;
    grn[0]  = lightsA[0]; grn[1]  = lightsB[0];
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_hist[i] = 64'd0;
        m_deb[i]  = 1'b0;
        m_req[i]  = 1'b0;
        m_grun[i] = 0;
      end else begin
        flip = 1'b1;
        for (int j = 1; j <= DEBOUNCE; j++) begin
          if (m_hist[i][j] == m_deb[i]) flip = 1'b0;
        end
        m_req[i] = (m_req[i] | m_deb[i]) & !grn[i];
        if (flip) m_deb[i] = !m_deb[i];
        m_grun[i] = grn[i] ? m_grun[i] + 1 : 0;
        m_hist[i] = {m_hist[i][62:0], sens[i]};
      end
    end
  endtask

  task automatic tick(input logic sa, input logic sb, input logic [2:0] la,
                      input logic [2:0] lb, input logic rst);
    sensA = sa; sensB = sb; lightsA = la; lightsB = lb; reset = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, RED, RED, 1'b1);
    tick(1'b0, 1'b0, RED, RED, 1'b1);
  endtask

  task automatic test_reset();
    logic [3:0] got;
    tick(1'b1, 1'b1, RED, RED, 1'b1);
    tick(1'b1, 1'b1, RED, RED, 1'b1);
    got = {carA, carB, reqA, reqB};
    checks++;
    if (got !== 4'b0000) $display("FAIL reset got=%b want=0000", got);
    else passed++;
    tick(1'b0, 1'b0, RED, RED, 1'b0);
    got = {carA, carB, reqA, reqB};
    checks++;
    if (got !== 4'b0000) $display("FAIL reset_after got=%b want=0000", got);
    else passed++;
  endtask

  task automatic test_clean_request();
    logic [3:0] got, want;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, 1'b0, RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = {k >= 7, 1'b0, k >= 7, 1'b0};
      checks++;
      if (got !== want) $display("FAIL clean_request edge=%0d got=%b want=%b", k, got, want);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got;
    do_reset();
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 6; c++) begin
        tick(1'b0, c < 3, RED, RED, 1'b0);
        got = {carA, carB, reqA, reqB};
        checks++;
        if (got !== 4'b0000) $display("FAIL glitch rep=%0d c=%0d got=%b want=0000", rep, c, got);
        else passed++;
      end
    end
  endtask

  task automatic test_latch_serve();
    logic [3:0] got, want;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick(k <= 7, 1'b0, (k >= 13) ? GRN : RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = (k >= 7 && k <= 12) ? 4'b1010 : 4'b0000;
      checks++;
      if (got !== want) $display("FAIL latch_serve edge=%0d got=%b want=%b", k, got, want);
      else passed++;
    end
  endtask

  task automatic test_min_green();
    logic [3:0] got, want;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      tick(1'b0, 1'b1, (k >= 11) ? GRN : RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = {1'b0, (k >= 7) && (k <= 10 || k >= 18), 1'b0, k >= 7};
      checks++;
      if (got !== want) $display("FAIL min_green edge=%0d got=%b want=%b", k, got, want);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] got, want;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b0, (k >= 6 && k <= 8) ? GRN : RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = {k >= 9, 1'b0, k >= 9, 1'b0};
      checks++;
      if (got !== want) $display("FAIL simultaneous edge=%0d got=%b want=%b", k, got, want);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] got, want;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick(k >= 10, 1'b1, (k >= 8) ? GRN : RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = {1'b0, k == 7, 1'b0, k >= 7};
      checks++;
      if (got !== want) $display("FAIL mid_reset_pre edge=%0d got=%b want=%b", k, got, want);
      else passed++;
    end
    tick(1'b1, 1'b0, RED, RED, 1'b1);
    got = {carA, carB, reqA, reqB};
    checks++;
    if (got !== 4'b0000) $display("FAIL mid_reset_edge got=%b want=0000", got);
    else passed++;
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 1'b0, RED, RED, 1'b0);
      got  = {carA, carB, reqA, reqB};
      want = {j >= 7, 1'b0, j >= 7, 1'b0};
      checks++;
      if (got !== want) $display("FAIL mid_reset_post edge=%0d got=%b want=%b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] got, want;
    logic       sa, sb, rst;
    logic [2:0] la, lb;
    sa = 1'b0; sb = 1'b0; la = RED; lb = RED;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) sa = ~sa;
      if ($urandom_range(0, 5) == 0) sb = ~sb;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       la = RED;
          1:       la = YEL;
          default: la = GRN;
        endcase
      end
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       lb = RED;
          1:       lb = YEL;
          default: lb = GRN;
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      tick(sa, sb, la, lb, rst);
      got  = {carA, carB, reqA, reqB};
      want = model_out();
      checks++;
      if (got !== want) $display("FAIL random n=%0d got=%b want=%b", n, got, want);
      else passed++;
    end
  endtask

  initial begin
    sensA = 1'b0; sensB = 1'b0; lightsA = RED; lightsB = RED; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = 64'd0; m_deb[i] = 1'b0; m_req[i] = 1'b0; m_grun[i] = 0;
    end
    test_reset();
    test_clean_request();
    test_glitch();
    test_latch_serve();
    test_min_green();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
